gonso_result_fifo: RTL and testbench

// - Downstream stage of the gonso Wishbone/Honzales wrapper: captures each {color, result} pair produced by the

---
 rtl/gonso_pkg.sv | 68 ++++++
 rtl/gonso_sync_fifo.sv | 70 +++++++
 rtl/gonso_result_fifo.sv | 153 +++++++++++++++
 tb/tb_gonso_result_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gonso_pkg.sv
// Shared register map, field positions and defaults for the gonso result FIFO window.
package gonso_pkg;

    localparam int unsigned DATA_W_DEF    = 20;
    localparam int unsigned COLOR_W_DEF   = 8;
    localparam int unsigned DEPTH_DEF     = 16;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h3003_0010;

    localparam logic [31:0] OFF_STATUS = 32'h0;
    localparam logic [31:0] OFF_DATA   = 32'h4;
    localparam logic [31:0] OFF_CTRL   = 32'h8;
    localparam logic [31:0] OFF_CMD    = 32'hC;

    localparam int unsigned ST_EMPTY_BIT = 16;
    localparam int unsigned ST_FULL_BIT  = 17;
    localparam int unsigned ST_OVF_BIT   = 18;
    localparam int unsigned ST_UNF_BIT   = 19;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_DROP_BIT  = 1;
    localparam int unsigned CTRL_IRQEN_BIT = 2;
    localparam int unsigned CTRL_THR_LSB   = 8;
    localparam int unsigned CTRL_THR_W     = 6;

    localparam int unsigned CMD_FLUSH_BIT = 0;
    localparam int unsigned CMD_CLEAR_BIT = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_STATUS,
        REG_DATA,
        REG_CTRL,
        REG_CMD
    } reg_sel_e;

    typedef struct packed {
        logic [CTRL_THR_W-1:0] thr;
        logic                  irq_en;
        logic                  drop;
        logic                  en;
    } ctrl_t;

    // Only exact word offsets inside the window hit a register; anything else is unmapped.
    function automatic reg_sel_e decode_reg(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        reg_sel_e    sel;
        off = addr - base;
        case (off)
            OFF_STATUS: sel = REG_STATUS;
            OFF_DATA:   sel = REG_DATA;
            OFF_CTRL:   sel = REG_CTRL;
            OFF_CMD:    sel = REG_CMD;
            default:    sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w                                = '0;
        w[CTRL_EN_BIT]                   = c.en;
        w[CTRL_DROP_BIT]                 = c.drop;
        w[CTRL_IRQEN_BIT]                = c.irq_en;
        w[CTRL_THR_LSB +: CTRL_THR_W]    = c.thr;
        return w;
    endfunction

endpackage

// File: rtl/gonso_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; push/pop are
// self-guarded so the count never runs past DEPTH or below zero.
module gonso_sync_fifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     count_next_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_eff, pop_eff;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CW'(DEPTH));
    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign rd_data_o    = mem_q[rd_ptr_q];

    always_comb begin
        pop_eff  = pop_i && !empty_o;
        push_eff = push_i && (!full_o || pop_eff);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_eff && !pop_eff)      count_d = count_q + CW'(1);
            else if (pop_eff && !push_eff) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push_eff) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/gonso_result_fifo.sv
// Result FIFO behind a Wishbone slave window: buffers {color, result} pairs from the
// Honzales core and raises a level interrupt when the fill level reaches a threshold.
module gonso_result_fifo
    import gonso_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned COLOR_W   = COLOR_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic [31:0]        wishbone_address,
    input  logic               wbs_we_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [3:0]         wbs_sel_i,
    output logic [31:0]        wbs_dat_o,
    output logic               wbs_ack_o,
    output logic               irq_o
);
    localparam int unsigned ENTRY_W = DATA_W + COLOR_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    ctrl_t       ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        ack_q, ack_d;
    logic        irq_q, irq_d;
    logic [31:0] dat_q, dat_d;

    reg_sel_e    reg_sel;
    logic        access, rd_acc, wr_acc;
    logic        pop_req, pop, push, flush, clr_sticky;
    logic        in_fire, ovf_set, unf_set;

    logic                  fifo_empty, fifo_full;
    logic [CNT_W-1:0]      fifo_count, fifo_count_nxt;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [31:0]           status_word, rd_word;
    logic [CTRL_THR_W-1:0] thr_eff;

    logic unused_bits;
    assign unused_bits = ^{wbs_dat_i[31:14], wbs_dat_i[7:3], wbs_sel_i[3:2]};

    always_comb begin
        access     = wbs_cyc_i && wbs_stb_i && !ack_q;
        rd_acc     = access && !wbs_we_i;
        wr_acc     = access && wbs_we_i;
        reg_sel    = decode_reg(wishbone_address, BASE_ADDR);
        pop_req    = rd_acc && (reg_sel == REG_DATA);
        flush      = wr_acc && (reg_sel == REG_CMD) && wbs_dat_i[CMD_FLUSH_BIT];
        clr_sticky = wr_acc && (reg_sel == REG_CMD) && wbs_dat_i[CMD_CLEAR_BIT];
    end

    assign in_ready = ctrl_q.en && (!fifo_full || ctrl_q.drop);

    // A pop in the same cycle frees a slot, so a drop-mode push at full is still stored;
    // flush discards the push outright without counting it as an overflow.
    always_comb begin
        in_fire = in_valid && in_ready;
        pop     = pop_req && !fifo_empty && !flush;
        push    = in_fire && (!fifo_full || pop) && !flush;
        ovf_set = in_fire && fifo_full && !pop && !flush;
        unf_set = pop_req && fifo_empty;
    end

    gonso_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (flush),
        .wr_data_i    ({in_color, in_data}),
        .rd_data_o    (fifo_head),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_nxt),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    always_comb begin
        status_word               = 32'(fifo_count);
        status_word[ST_EMPTY_BIT] = fifo_empty;
        status_word[ST_FULL_BIT]  = fifo_full;
        status_word[ST_OVF_BIT]   = ovf_q;
        status_word[ST_UNF_BIT]   = unf_q;

        rd_word = '0;
        case (reg_sel)
            REG_STATUS: rd_word = status_word;
            REG_DATA:   rd_word = fifo_empty ? '0 : 32'(fifo_head);
            REG_CTRL:   rd_word = ctrl_word(ctrl_q);
            default:    rd_word = '0;
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_acc && (reg_sel == REG_CTRL)) begin
            if (wbs_sel_i[0]) begin
                ctrl_d.en     = wbs_dat_i[CTRL_EN_BIT];
                ctrl_d.drop   = wbs_dat_i[CTRL_DROP_BIT];
                ctrl_d.irq_en = wbs_dat_i[CTRL_IRQEN_BIT];
            end
            if (wbs_sel_i[1]) begin
                ctrl_d.thr = wbs_dat_i[CTRL_THR_LSB +: CTRL_THR_W];
            end
        end

        ovf_d = (ovf_q && !clr_sticky) || ovf_set;
        unf_d = (unf_q && !clr_sticky) || unf_set;

        ack_d = access;
        dat_d = access ? (wbs_we_i ? '0 : rd_word) : dat_q;

        // Evaluated on next-state values so irq_o tracks the count the bus will see.
        thr_eff = (ctrl_d.thr == '0) ? CTRL_THR_W'(1) : ctrl_d.thr;
        irq_d   = ctrl_d.irq_en && (fifo_count_nxt != '0)
                  && (32'(fifo_count_nxt) >= 32'(thr_eff));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            ack_q  <= 1'b0;
            irq_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            ack_q  <= ack_d;
            irq_q  <= irq_d;
            dat_q  <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_gonso_result_fifo.sv
// Directed and randomized bench for gonso_result_fifo against a queue-based reference model.
module tb_gonso_result_fifo;

    localparam int          DEPTH    = 16;
    localparam logic [31:0] BASE     = 32'h3003_0010;
    localparam logic [31:0] A_STATUS = BASE;
    localparam logic [31:0] A_DATA   = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;
    localparam logic [31:0] A_CMD    = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic [7:0]  in_color;
    logic        cyc, stb, we;
    logic [31:0] addr, dat_i, dat_o;
    logic [3:0]  sel;
    logic        ack, irq;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    logic [27:0] q[$];
    logic [31:0] m_ctrl;
    bit          m_ovf, m_unf;

    always #5 clk = ~clk;

    gonso_result_fifo #(
        .DATA_W    (20),
        .COLOR_W   (8),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_color         (in_color),
        .wbs_cyc_i        (cyc),
        .wbs_stb_i        (stb),
        .wishbone_address (addr),
        .wbs_we_i         (we),
        .wbs_dat_i        (dat_i),
        .wbs_sel_i        (sel),
        .wbs_dat_o        (dat_o),
        .wbs_ack_o        (ack),
        .irq_o            (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready();
        return m_ctrl[0] && ((q.size() < DEPTH) || m_ctrl[1]);
    endfunction

    function automatic logic m_irq();
        int thr;
        thr = (m_ctrl[13:8] == 6'd0) ? 1 : int'(m_ctrl[13:8]);
        return m_ctrl[2] && (q.size() != 0) && (q.size() >= thr);
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s     = 32'(q.size());
        s[16] = (q.size() == 0);
        s[17] = (q.size() == DEPTH);
        s[18] = m_ovf;
        s[19] = m_unf;
        return s;
    endfunction

    // One bus access (two cycles: request, ack) and/or one producer beat, with the model
    // advanced by the rules: read sees pre-cycle state, pop before push, flush discards all.
    task automatic step(input bit bus, input bit wr, input logic [31:0] a, input logic [31:0] wdata,
                        input logic [3:0] bsel, input bit pv, input logic [27:0] pent,
                        output logic [31:0] rdata);
        logic [31:0] exp_rd;
        logic [31:0] off;
        logic        ready;
        bit          do_flush;
        ready    = m_ready();
        check("in_ready", 32'(in_ready), 32'(ready));
        exp_rd   = '0;
        do_flush = 0;
        off      = a - BASE;
        if (bus && !wr) begin
            if (off == 32'h0)      exp_rd = m_status();
            else if (off == 32'h4) exp_rd = (q.size() > 0) ? {4'b0, q[0]} : '0;
            else if (off == 32'h8) exp_rd = m_ctrl;
        end

        cyc = bus; stb = bus; we = wr; addr = a; dat_i = wdata; sel = bsel;
        in_valid = pv; in_data = pent[19:0]; in_color = pent[27:20];
        #1;
        if (bus) check("ack_early", 32'(ack), 32'd0);

        if (bus && !wr && off == 32'h4) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_unf = 1;
        end
        if (bus && wr && off == 32'h8) begin
            if (bsel[0]) m_ctrl[2:0]  = wdata[2:0];
            if (bsel[1]) m_ctrl[13:8] = wdata[13:8];
        end
        if (bus && wr && off == 32'hC) begin
            do_flush = wdata[0];
            if (wdata[1]) begin m_ovf = 0; m_unf = 0; end
        end
        if (pv && ready && !do_flush) begin
            if (q.size() < DEPTH) q.push_back(pent);
            else m_ovf = 1;
        end
        if (do_flush) q.delete();

        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0; in_valid = 0;
        check("irq", 32'(irq), 32'(m_irq()));
        rdata = '0;
        if (bus) begin
            check("ack", 32'(ack), 32'd1);
            if (!wr) check("rdata", dat_o, exp_rd);
            rdata = dat_o;
            @(posedge clk); #1;
            check("ack_drop", 32'(ack), 32'd0);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        step(1'b1, 1'b0, a, '0, 4'hF, 1'b0, '0, d);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        logic [31:0] dummy;
        step(1'b1, 1'b1, a, v, 4'hF, 1'b0, '0, dummy);
    endtask

    task automatic push(input logic [27:0] e);
        logic [31:0] dummy;
        step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, e, dummy);
    endtask

    initial begin
        logic [31:0] d;
        rst = 1; in_valid = 0; in_data = '0; in_color = '0;
        cyc = 0; stb = 0; we = 0; addr = '0; dat_i = '0; sel = '0;
        q.delete(); m_ctrl = '0; m_ovf = 0; m_unf = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        check("rst_irq",   32'(irq),      32'd0);
        check("rst_ack",   32'(ack),      32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_dat",   dat_o,         32'd0);
        rd(A_STATUS, d);
        check("rst_status", d, 32'h0001_0000);

        // basic ordering
        wr(A_CTRL, 32'h1);
        push(28'hA1_12345);
        push(28'h02_00001);
        push(28'hFF_FFFFF);
        rd(A_DATA, d);   check("data0", d, 32'h0A1_12345);
        rd(A_DATA, d);   check("data1", d, 32'h002_00001);
        rd(A_DATA, d);   check("data2", d, 32'h0FF_FFFFF);
        rd(A_STATUS, d); check("drained", d, 32'h0001_0000);

        // backpressure
        for (int i = 0; i < 17; i++) push(28'($urandom));
        rd(A_STATUS, d); check("bp_status", d, 32'h0002_0010);
        rd(A_DATA, d);
        check("bp_ready", 32'(in_ready), 32'd1);
        wr(A_CMD, 32'h1);
        rd(A_STATUS, d); check("bp_flushed", d, 32'h0001_0000);

        // drop mode
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 20; i++) push(28'($urandom));
        rd(A_STATUS, d); check("drop_status", d, 32'h0006_0010);
        for (int i = 0; i < 16; i++) rd(A_DATA, d);
        wr(A_CMD, 32'h2);
        rd(A_STATUS, d); check("drop_cleared", d, 32'h0001_0000);

        // full in drop mode with a simultaneous pop: push is stored, not dropped
        for (int i = 0; i < 16; i++) push(28'($urandom));
        step(1'b1, 1'b0, A_DATA, '0, 4'hF, 1'b1, 28'($urandom), d);
        rd(A_STATUS, d); check("full_pop_push", d, 32'h0002_0010);
        wr(A_CMD, 32'h1);

        // simultaneous push+pop, underflow, push+flush
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 5; i++) push(28'($urandom));
        step(1'b1, 1'b0, A_DATA, '0, 4'hF, 1'b1, 28'($urandom), d);
        rd(A_STATUS, d); check("pp_count5", d, 32'h0000_0005);
        wr(A_CMD, 32'h1);
        rd(A_DATA, d);   check("unf_data", d, 32'h0);
        rd(A_STATUS, d); check("unf_status", d, 32'h0009_0000);
        step(1'b1, 1'b0, A_DATA, '0, 4'hF, 1'b1, 28'($urandom), d);
        check("unf_push_data", d, 32'h0);
        rd(A_STATUS, d); check("unf_push_lands", d, 32'h0008_0001);
        wr(A_CMD, 32'h3);
        push(28'($urandom));
        push(28'($urandom));
        step(1'b1, 1'b1, A_CMD, 32'h1, 4'hF, 1'b1, 28'($urandom), d);
        rd(A_STATUS, d); check("push_flush", d, 32'h0001_0000);

        // byte lanes and unmapped addresses
        step(1'b1, 1'b1, A_CTRL, 32'hFFFF_FFFF, 4'b0010, 1'b0, '0, d);
        rd(A_CTRL, d); check("ctrl_lane1", d, 32'h0000_3F01);
        wr(BASE + 32'h10, 32'hFFFF_FFFF);
        wr(BASE + 32'h2,  32'hFFFF_FFFF);
        rd(BASE + 32'h10, d); check("unmapped_hi", d, 32'h0);
        rd(BASE + 32'h2,  d); check("unmapped_odd", d, 32'h0);
        rd(32'h0, d);         check("unmapped_lo", d, 32'h0);
        rd(A_CMD, d);         check("cmd_reads0", d, 32'h0);
        rd(A_CTRL, d);        check("ctrl_kept", d, 32'h0000_3F01);

        // threshold interrupt and pointer wrap
        wr(A_CTRL, 32'h0405);
        for (int i = 0; i < 4; i++) push(28'($urandom));
        check("irq_at_thr", 32'(irq), 32'd1);
        rd(A_DATA, d);
        check("irq_below_thr", 32'(irq), 32'd0);
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b0, A_DATA, '0, 4'hF, 1'b1, 28'($urandom), d);
        for (int i = 0; i < 3; i++) rd(A_DATA, d);
        rd(A_STATUS, d); check("wrap_drained", d, 32'h0001_0000);
        wr(A_CTRL, 32'h0005);
        push(28'($urandom));
        check("irq_thr0", 32'(irq), 32'd1);

        // reset in the middle of an access drops it and the buffered entry
        cyc = 1; stb = 1; we = 0; addr = A_DATA; rst = 1;
        @(posedge clk); #1;
        cyc = 0; stb = 0; rst = 0;
        check("rstx_ack",   32'(ack),      32'd0);
        check("rstx_irq",   32'(irq),      32'd0);
        check("rstx_ready", 32'(in_ready), 32'd0);
        q.delete(); m_ctrl = '0; m_ovf = 0; m_unf = 0;
        rd(A_STATUS, d); check("rstx_status", d, 32'h0001_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
